// File: rtl/cella_pkg.sv
// cella_pkg: shared types, sizes and helpers for the CELLA storage bank.
// Build option: CELLA_MAC_ACC_EN selects the saturating MAC accumulator.
package cella_pkg;

  localparam int ROWS    = 4;
  localparam int WORD_W  = 8;
  localparam int QUERY_W = 4;
  localparam int ACC_W   = 6;
  localparam int ADDR_W  = $clog2(ROWS);
  localparam int PC_W    = $clog2(QUERY_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    CAM,
    SWITCH
  } bank_state_e;

  typedef logic [ROWS-1:0][WORD_W-1:0]  row_arr_t;
  typedef logic [ROWS-1:0][QUERY_W-1:0] key_arr_t;

  function automatic logic [PC_W-1:0] popcount(
    input logic [QUERY_W-1:0] v
  );
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < QUERY_W; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cella_cam_cmp.sv
// cella_cam_cmp: per-row key equality compare, one hit bit per row.
// Purely combinational; the bank registers the hit vector.
module cella_cam_cmp
  import cella_pkg::*;
(
  input  key_arr_t           keys,
  input  logic [QUERY_W-1:0] query,
  output logic [ROWS-1:0]    hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < ROWS; i++) begin
      hit[i] = (keys[i] == query);
    end
  end

endmodule

// File: rtl/cella_bank.sv
// cella_bank: 4x8 CELLA bank with MAC read/write, CAM search and MAC result.
// Build option: CELLA_MAC_ACC_EN selects the saturating MAC accumulator.
module cella_bank
  import cella_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               CS,
  input  logic               MAC_en,
  input  logic               w_en,
  input  logic               read_bar,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WORD_W-1:0]  word,
  input  logic [QUERY_W-1:0] query,
  output logic [WORD_W-1:0]  dout,
  output logic               dout_valid,
  output logic [ROWS-1:0]    match,
  output logic               match_valid,
  output logic [ACC_W-1:0]   mac_out,
  output logic               busy
);

  bank_state_e state_q;
  bank_state_e state_d;

  row_arr_t rows_q;
  key_arr_t keys;

  logic [WORD_W-1:0] row_sel;
  logic [PC_W-1:0]   pcnt;
  logic [ROWS-1:0]   hit;
  logic [ACC_W-1:0]  mac_q;
  logic [ACC_W-1:0]  mac_d;

  logic mac_op;
  logic rd_op;
  logic wr_op;
  logic cam_op;
  logic mac_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!CS) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = MAC_en ? MAC : CAM;
        MAC:     state_d = MAC_en ? MAC : SWITCH;
        CAM:     state_d = MAC_en ? SWITCH : CAM;
        SWITCH:  state_d = MAC_en ? MAC : CAM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == SWITCH);
  end

  // A mode toggle sampled in MAC/CAM is a switch request, not an operation.
  always_comb begin
    mac_op  = CS && MAC_en && (state_q == MAC);
    rd_op   = mac_op && !w_en;
    wr_op   = mac_op && w_en;
    cam_op  = CS && !MAC_en && (state_q == CAM);
    mac_clr = !CS || ((state_d == CAM) && (state_q != CAM));
  end

  always_comb begin
    keys = '0;
    for (int i = 0; i < ROWS; i++) begin
      keys[i] = rows_q[i][QUERY_W-1:0];
    end
  end

  always_comb begin
    row_sel = rows_q[addr];
    pcnt    = popcount(query & row_sel[QUERY_W-1:0]);
  end

  cella_cam_cmp u_cam_cmp (
    .keys  (keys),
    .query (query),
    .hit   (hit)
  );

`ifdef CELLA_MAC_ACC_EN
  logic [ACC_W:0] acc_sum;

  always_comb begin
    acc_sum = {1'b0, mac_q} + (ACC_W + 1)'(pcnt);
    mac_d   = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  end
`else
  always_comb begin
    mac_d = ACC_W'(pcnt);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= '0;
    end else if (wr_op) begin
      rows_q[addr] <= word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_op;
      if (rd_op) begin
        dout <= read_bar ? ~row_sel : row_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match       <= '0;
      match_valid <= 1'b0;
    end else begin
      match_valid <= cam_op;
      if (cam_op) begin
        match <= hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_q <= '0;
    end else if (mac_clr) begin
      mac_q <= '0;
    end else if (rd_op) begin
      mac_q <= mac_d;
    end
  end

  assign mac_out = mac_q;

endmodule

// File: tb/tb_cella_bank.sv
// tb_cella_bank: directed scoreboard bench for cella_bank.
// Build option: CELLA_MAC_ACC_EN switches the expected mac_out model.
module tb_cella_bank;

  logic       clk;
  logic       rst_n;
  logic       CS;
  logic       MAC_en;
  logic       w_en;
  logic       read_bar;
  logic [1:0] addr;
  logic [7:0] word;
  logic [3:0] query;
  logic [7:0] dout;
  logic       dout_valid;
  logic [3:0] match;
  logic       match_valid;
  logic [5:0] mac_out;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    logic [5:0] m;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [3:0] mt_q[$];
  logic [7:0] mrow[4];
  int         macc;
  int         total;
  int         bad;

  cella_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .CS          (CS),
    .MAC_en      (MAC_en),
    .w_en        (w_en),
    .read_bar    (read_bar),
    .addr        (addr),
    .word        (word),
    .query       (query),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .match       (match),
    .match_valid (match_valid),
    .mac_out     (mac_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pc4(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic tick();
    rd_exp_t e;
    logic [3:0] m;
    @(posedge clk);
    #1;
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk("rd_valid", 32'(dout_valid), 32'd1);
      chk("rd_dout", 32'(dout), 32'(e.d));
      chk("rd_mac", 32'(mac_out), 32'(e.m));
    end
    if (mt_q.size() > 0) begin
      m = mt_q.pop_front();
      chk("cam_valid", 32'(match_valid), 32'd1);
      chk("cam_match", 32'(match), 32'(m));
    end
  endtask

  task automatic go_mac();
    CS = 1'b1; MAC_en = 1'b1; w_en = 1'b0;
    tick();
    chk("enter_busy", 32'(busy), 32'd0);
  endtask

  task automatic wr(input int a, input logic [7:0] w);
    CS = 1'b1; MAC_en = 1'b1; w_en = 1'b1;
    addr = 2'(a); word = w;
    mrow[a] = w;
    tick();
    chk("wr_valid", 32'(dout_valid), 32'd0);
  endtask

  task automatic rd(input int a, input logic rb);
    rd_exp_t e;
    int p;
    CS = 1'b1; MAC_en = 1'b1; w_en = 1'b0;
    addr = 2'(a); read_bar = rb;
    p = pc4(query & mrow[a][3:0]);
`ifdef CELLA_MAC_ACC_EN
    macc = (macc + p > 63) ? 63 : macc + p;
`else
    macc = p;
`endif
    e.d = rb ? ~mrow[a] : mrow[a];
    e.m = 6'(macc);
    rd_q.push_back(e);
    tick();
  endtask

  task automatic cam(input logic [3:0] q, input logic we);
    logic [3:0] m;
    CS = 1'b1; MAC_en = 1'b0; w_en = we;
    addr = 2'd0; word = 8'hEE; query = q;
    for (int i = 0; i < 4; i++) m[i] = (mrow[i][3:0] == q);
    mt_q.push_back(m);
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_dv"}, 32'(dout_valid), 32'd0);
    chk({tag, "_match"}, 32'(match), 32'd0);
    chk({tag, "_mv"}, 32'(match_valid), 32'd0);
    chk({tag, "_mac"}, 32'(mac_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; macc = 0;
    for (int i = 0; i < 4; i++) mrow[i] = 8'h00;
    rst_n = 1'b0; CS = 1'b0; MAC_en = 1'b0; w_en = 1'b0;
    read_bar = 1'b0; addr = 2'd0; word = 8'h00; query = 4'hF;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    go_mac();
    wr(0, 8'h27); wr(1, 8'hA4); wr(2, 8'h7A); wr(3, 8'h6C);
    for (int i = 0; i < 4; i++) rd(i, 1'b0);

    CS = 1'b0;
    macc = 0;
    tick();
    chk("cs0_dv", 32'(dout_valid), 32'd0);
    chk("cs0_mac", 32'(mac_out), 32'd0);
    go_mac();
    rd(0, 1'b0); rd(2, 1'b1); rd(1, 1'b0); rd(3, 1'b1);

    CS = 1'b1; MAC_en = 1'b0; w_en = 1'b0;
    tick();
    chk("to_cam_busy", 32'(busy), 32'd1);
    macc = 0;
    tick();
    chk("to_cam_idle", 32'(busy), 32'd0);
    chk("cam_mac", 32'(mac_out), 32'd0);
    cam(4'hC, 1'b0);
    cam(4'h4, 1'b1);
    cam(4'h0, 1'b0);
    cam(4'hA, 1'b0);
    chk("cam_mac2", 32'(mac_out), 32'd0);

    query = 4'hF;
    CS = 1'b1; MAC_en = 1'b1; w_en = 1'b0;
    tick();
    chk("to_mac_busy", 32'(busy), 32'd1);
    chk("to_mac_mv", 32'(match_valid), 32'd0);
    tick();
    chk("to_mac_idle", 32'(busy), 32'd0);
    rd(0, 1'b0);

    wr(1, 8'h5B);
    rd(1, 1'b0);
    CS = 1'b0;
    macc = 0;
    tick();
    chk("cs0b_dv", 32'(dout_valid), 32'd0);
    chk("cs0b_mv", 32'(match_valid), 32'd0);
    chk("cs0b_mac", 32'(mac_out), 32'd0);
    chk("cs0b_busy", 32'(busy), 32'd0);
    go_mac();
    rd(1, 1'b0);

    wr(2, 8'hFF);
    for (int i = 0; i < 16; i++) rd(2, 1'b0);

    rd(3, 1'b1);
    CS = 1'b1; MAC_en = 1'b1; w_en = 1'b0; addr = 2'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    rd_q.delete();
    mt_q.delete();
    macc = 0;
    for (int i = 0; i < 4; i++) mrow[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    go_mac();
    for (int i = 0; i < 4; i++) rd(i, 1'b0);

    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("mt_q_empty", 32'(mt_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cella_bank.md
# cella_bank

Clocked 4-row × 8-bit CELLA storage bank that implements the responder side of the bank control interface (CS, MAC_en, w_en, read_bar, addr, word, query). It stores words in MAC mode, returns true (Q) or complement (QB) read data, and runs single-cycle CAM searches over all rows. It also accumulates a popcount-based MAC result. The block sits directly under the bank driver and feeds the array-level readout and match logic.

## Interface
- ROWS, 4, number of rows; addr width is log2(ROWS)
- WORD_W, 8, stored word width
- QUERY_W, 4, query and CAM key width; compared against the low QUERY_W bits of each row
- ACC_W, 6, MAC accumulator width
- clk  in  1  bank clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- CS  in  1  chip select; 0 forces IDLE
- MAC_en  in  1  1 = MAC (read/write) mode, 0 = CAM mode
- w_en  in  1  write enable (MAC mode)
- read_bar  in  1  0 = read Q, 1 = read QB (bitwise complement)
- addr  in  2  row address
- word  in  8  write data
- query  in  4  MAC input vector / CAM search key
- dout  out  8  registered read data
- dout_valid  out  1  dout updated this cycle
- match  out  4  registered per-row CAM hit vector, bit i = row i
- match_valid  out  1  match updated this cycle
- mac_out  out  ACC_W  MAC result
- busy  out  1  mode switch in progress

## Operation
- FSM states: IDLE, MAC, CAM, SWITCH.
- IDLE:
  - CS=1 and MAC_en=1 → MAC.
  - CS=1 and MAC_en=0 → CAM.
- MAC or CAM: if MAC_en differs from the current mode → SWITCH.
- SWITCH: busy=1 for exactly one cycle. Writes are ignored and both valids stay low. Next state is the mode selected by MAC_en at exit.
- CS=0 in any state → IDLE on the next edge. Storage is retained. Valids drop, and the accumulator clears.
- MAC write: state MAC, CS=1, w_en=1 → row[addr] ← word. No read, dout_valid=0.
- MAC read: state MAC, CS=1, w_en=0:
  - dout ← read_bar ? ~row[addr] : row[addr]; dout_valid=1.
  - p = popcount(query & row[addr][3:0]), using the stored value regardless of read_bar.
  - Accumulator ← min(acc + p, 2^ACC_W−1), saturating.
- CAM: state CAM, CS=1:
  - match[i] ← (row[i][3:0] == query); match_valid=1.
  - Storage is never written in CAM; w_en is ignored.
- Entering CAM from any state clears the accumulator.
- dout and match hold their last value when not updated.

## Timing
- Reset values: dout=0, dout_valid=0, match=0, match_valid=0, mac_out=0, busy=0, all rows=0, state=IDLE.
- Read latency is 1 cycle: inputs sampled at edge N appear on dout and mac_out after edge N.
- Write at edge N is visible to a read sampled at edge N+1.
- CAM latency is 1 cycle. A CAM search at edge N+1 sees a write made at edge N (only possible across a SWITCH).
- MAC_en toggle sampled at edge N: SWITCH after N, new mode active after N+1, first result after N+2.
- rst_n assertion mid-operation clears everything immediately. Operation resumes from IDLE on the first edge after release.
- Simultaneous CS deassertion and MAC_en toggle: CS wins, next state is IDLE.

## Configuration
- CELLA_MAC_ACC_EN defined: mac_out is the saturating accumulator described above.
- Not defined: no accumulator register. mac_out is the registered per-read p, zero-extended, and holds between reads.

## Structure
- Shared package cella_pkg holds:
  - the bank state enum (IDLE, MAC, CAM, SWITCH);
  - ROWS, WORD_W, QUERY_W, ACC_W defaults;
  - a popcount function.
- One sub-module: cella_cam_cmp, a combinational per-row QUERY_W equality compare producing the 4-bit hit vector. The top registers its output.

## Test plan
- Reset, then CS=1, MAC_en=1, writes 0x27/0xA4/0x7A/0x6C to addr 0–3 → row readback via Q gives 0x27, 0xA4, 0x7A, 0x6C, each with a 1-cycle delay.
- query=4'hF, reads addr0 Q, addr2 QB, addr1 Q, addr3 QB → dout 0x27, 0x85, 0xA4, 0x93. With the macro, mac_out reads 3, 5, 6, 8; without it, 3, 2, 1, 2.
- MAC_en 1→0 → busy=1 for one cycle. With query=4'hC, match=4'b1000; with query=4'h4, match=4'b0010; with query=4'h0, match=4'b0000. mac_out=0.
- CAM→MAC → SWITCH, then read addr0 Q gives 0x27, proving data is retained across the mode switch.
- Write addr1 then read addr1 on the next cycle → new value returned. CS=0 for one cycle → valids low, state IDLE, data retained.
- rst_n pulsed low mid read sequence → all outputs 0 immediately, rows read back 0x00.
